// File: rtl/lvds_tx_arbiter.sv
// lvds_tx_arbiter: round-robin arbiter feeding a single serial LVDS lane.
// Each granted word goes out as one start bit (0), then DATA_W data bits
// LSB first, then STOP_CYCLES high cycles. The lane idles high, and at least
// one idle cycle separates consecutive frames.
module lvds_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 24,
    parameter int STOP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     frame_done
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int STP_W = $clog2(STOP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     cand;
    logic               found;
    logic               grant;
    logic [DATA_W-1:0]  win_word;
    logic [DATA_W-1:0]  shift, shift_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [STP_W-1:0]   stop_cnt, stop_cnt_nxt;
    logic               tx_nxt;
    logic               frame_done_nxt;
    logic [PTR_W-1:0]   grant_id_nxt;

    // Advance a requester index by one, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N_REQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(N_REQ)) begin
                cand = cand - (PTR_W + 1)'(N_REQ);
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    // Select the winner's word from the flattened request bus.
    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A grant only happens from IDLE with scheduling enabled; reset suppresses it outright.
    assign grant = (state == S_IDLE) && en && found && !rst;

    // One-hot handshake toward the winning requester, present only in the granting cycle.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic; tx is computed one cycle ahead so the lane pin is a flop.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        grant_id_nxt   = grant_id;
        shift_nxt      = shift;
        bit_cnt_nxt    = bit_cnt;
        stop_cnt_nxt   = stop_cnt;
        tx_nxt         = 1'b1;
        frame_done_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt    = S_START;
                    shift_nxt    = win_word;
                    grant_id_nxt = winner;
                    ptr_nxt      = ptr_inc(winner);
                    tx_nxt       = 1'b0;
                end
            end

            S_START: begin
                state_nxt   = S_DATA;
                tx_nxt      = shift[0];
                shift_nxt   = shift >> 1;
                bit_cnt_nxt = '0;
            end

            S_DATA: begin
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                    state_nxt    = S_STOP;
                    bit_cnt_nxt  = '0;
                    stop_cnt_nxt = '0;
                    tx_nxt       = 1'b1;
                end else begin
                    tx_nxt      = shift[0];
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (stop_cnt == STP_W'(STOP_CYCLES - 1)) begin
                    // Always return to IDLE so frames never abut.
                    state_nxt    = S_IDLE;
                    stop_cnt_nxt = '0;
                end else begin
                    stop_cnt_nxt   = stop_cnt + 1'b1;
                    frame_done_nxt = (stop_cnt == STP_W'(STOP_CYCLES - 2));
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight and idles the lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            grant_id   <= grant_id_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx         <= tx_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed bench for lvds_tx_arbiter with a behavioural 24-bit serial receiver on the lane.
module tb_lvds_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int SC = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [1:0]     grant_id;
    logic           frame_done;

    int compared   = 0;
    int mismatched = 0;

    lvds_tx_arbiter #(.N_REQ(N), .DATA_W(W), .STOP_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Far-end receiver: start bit, 24 bits LSB first, one ignored cycle, then stop sample.
    bit           rx_on     = 1'b0;
    int           rx_state  = 0;
    int           rx_bit    = 0;
    int           rx_errs   = 0;
    int           rx_pulses = 0;
    logic [W-1:0] rx_shift  = '0;
    logic [W-1:0] data_out  = '0;
    logic         rx_ena    = 1'b0;
    logic [W-1:0] rx_q[$];

    always @(negedge clk) begin
        rx_ena <= 1'b0;
        if (!rx_on) begin
            rx_state <= 0;
        end else begin
            case (rx_state)
                0: if (tx == 1'b0) begin rx_state <= 1; rx_bit <= 0; end
                1: begin
                    rx_shift <= {tx, rx_shift[W-1:1]};
                    rx_bit   <= rx_bit + 1;
                    if (rx_bit == W - 1) rx_state <= 2;
                end
                2: rx_state <= 3;
                default: begin
                    if (tx == 1'b1) begin
                        data_out <= rx_shift;
                        rx_ena   <= 1'b1;
                        rx_q.push_back(rx_shift);
                    end else begin
                        rx_errs <= rx_errs + 1;
                    end
                    rx_state <= 0;
                end
            endcase
        end
    end

    always @(posedge rx_ena) rx_pulses++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int r, input logic [W-1:0] w);
        req_data[r*W +: W] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int limit, output logic [N-1:0] rdy, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                rdy = req_ready;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_frame_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        req_valid = '1;
        req_data = '0;
        step();
        step();
        @(negedge clk);
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        req_valid = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_word();
        logic [W-1:0] got;
        bit fd_early;
        got = '0;
        fd_early = 1'b0;
        set_word(2, 24'hA5C3F0);
        req_valid = 4'b0100;
        @(negedge clk);
        compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL single_ready_after: got %b want 0000", req_ready); end
        compared++; if (tx !== 1'b0) begin mismatched++; $display("FAIL single_start_bit: got %b want 0", tx); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", busy); end
        compared++; if (grant_id !== 2'd2) begin mismatched++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        for (int k = 0; k < W; k++) begin
            step();
            @(negedge clk);
            got[k] = tx;
            if (frame_done !== 1'b0) fd_early = 1'b1;
        end
        // 0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 read LSB first
        compared++; if (got !== 24'hA5C3F0) begin mismatched++; $display("FAIL single_data_bits: got %h want a5c3f0", got); end
        compared++; if (fd_early !== 1'b0) begin mismatched++; $display("FAIL single_fd_in_data: got %b want 0", fd_early); end
        step();
        @(negedge clk);
        compared++; if (tx !== 1'b1 || frame_done !== 1'b0) begin mismatched++; $display("FAIL single_stop1: got tx=%b fd=%b want tx=1 fd=0", tx, frame_done); end
        step();
        @(negedge clk);
        compared++; if (tx !== 1'b1 || frame_done !== 1'b1) begin mismatched++; $display("FAIL single_stop2: got tx=%b fd=%b want tx=1 fd=1", tx, frame_done); end
        step();
        @(negedge clk);
        compared++; if (busy !== 1'b0 || frame_done !== 1'b0 || tx !== 1'b1) begin mismatched++; $display("FAIL single_idle: got busy=%b fd=%b tx=%b want 0 0 1", busy, frame_done, tx); end
        compared++; if (dut.ptr !== 2'd3) begin mismatched++; $display("FAIL single_ptr: got %0d want 3", dut.ptr); end
        step();
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int ng = 0;
        int last = 0;
        int run = 0;
        bit prev_rdy = 1'b0;
        logic [N-1:0] want;
        bit ok;
        rst = 1'b1;
        en = 1'b1;
        // MSB of every word is 0 so the high run before each start bit is exactly stop + idle.
        set_word(0, 24'h111111);
        set_word(1, 24'h222222);
        set_word(2, 24'h333333);
        set_word(3, 24'h444444);
        req_valid = '1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (prev_rdy && tx === 1'b0 && ng > 1) begin
                compared++; if (run != 3) begin mismatched++; $display("FAIL rr_gap: got %0d high cycles want 3", run); end
            end
            if (req_ready != '0) begin
                if (ng < 5) begin
                    want = 4'(1 << exp_id[ng]);
                    compared++; if (req_ready !== want) begin mismatched++; $display("FAIL rr_order%0d: got %b want %b", ng, req_ready, want); end
                end
                if (ng > 0) begin
                    compared++; if (c - last != 28) begin mismatched++; $display("FAIL rr_period: got %0d want 28", c - last); end
                end
                last = c;
                ng++;
            end
            run = (tx === 1'b1) ? run + 1 : 0;
            prev_rdy = (req_ready != '0);
        end
        compared++; if (ng != 5) begin mismatched++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
        en = 1'b0;
        wait_frame_done(40, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL rr_final_done: got none want pulse"); end
        step();
        req_valid = '0;
        en = 1'b1;
    endtask

    task automatic test_ptr_wrap();
        logic [N-1:0] rdy;
        bit ok;
        do_reset();
        set_word(1, 24'h0F0F0F);
        req_valid = 4'b0010;
        wait_grant(10, rdy, ok);
        compared++; if (!ok || rdy !== 4'b0010) begin mismatched++; $display("FAIL wrap_first: got %b want 0010", rdy); end
        step();
        compared++; if (dut.ptr !== 2'd2) begin mismatched++; $display("FAIL wrap_ptr: got %0d want 2", dut.ptr); end
        set_word(3, 24'h333333);
        req_valid = 4'b1010;
        wait_grant(40, rdy, ok);
        compared++; if (!ok || rdy !== 4'b1000) begin mismatched++; $display("FAIL wrap_second: got %b want 1000", rdy); end
        step();
        req_valid = 4'b0010;
        wait_grant(40, rdy, ok);
        compared++; if (!ok || rdy !== 4'b0010) begin mismatched++; $display("FAIL wrap_third: got %b want 0010", rdy); end
        step();
        req_valid = '0;
        wait_frame_done(40, ok);
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] rdy;
        bit ok;
        bit fd_seen;
        do_reset();
        set_word(2, 24'h5A5A5A);
        req_valid = 4'b0100;
        wait_grant(10, rdy, ok);
        compared++; if (!ok || rdy !== 4'b0100) begin mismatched++; $display("FAIL midrst_grant: got %b want 0100", rdy); end
        step();
        set_word(3, 24'h0000FF);
        req_valid = 4'b1100;
        for (int i = 0; i < 11; i++) step();
        @(negedge clk);
        // bit 10 of 0x5A5A5A is 0
        compared++; if (tx !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL midrst_bit10: got tx=%b busy=%b want 0 1", tx, busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL midrst_tx: got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL midrst_grant_id: got %0d want 0", grant_id); end
        compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL midrst_next_grant: got %b want 0100", req_ready); end
        fd_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) fd_seen = 1'b1;
        end
        compared++; if (fd_seen !== 1'b0) begin mismatched++; $display("FAIL midrst_no_done: got %b want 0", fd_seen); end
        step();
        req_valid = '0;
        wait_frame_done(40, ok);
        step();
    endtask

    task automatic test_enable();
        logic [N-1:0] rdy;
        bit ok;
        bit any_rdy;
        bit any_low;
        do_reset();
        en = 1'b0;
        set_word(0, 24'h00C0DE);
        req_valid = 4'b0001;
        any_rdy = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != '0) any_rdy = 1'b1;
            if (tx !== 1'b1) any_low = 1'b1;
        end
        compared++; if (any_rdy !== 1'b0) begin mismatched++; $display("FAIL en_off_ready: got %b want 0", any_rdy); end
        compared++; if (any_low !== 1'b0) begin mismatched++; $display("FAIL en_off_tx: got %b want 0", any_low); end
        step();
        en = 1'b1;
        wait_grant(5, rdy, ok);
        compared++; if (!ok || rdy !== 4'b0001) begin mismatched++; $display("FAIL en_on_grant: got %b want 0001", rdy); end
        step();
        set_word(0, 24'h0BEEF0);
        for (int i = 0; i < 5; i++) step();
        en = 1'b0;
        wait_frame_done(40, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL en_drop_done: got none want pulse"); end
        step();
        any_rdy = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != '0 || busy !== 1'b0) any_rdy = 1'b1;
            if (tx !== 1'b1) any_low = 1'b1;
        end
        compared++; if (any_rdy !== 1'b0) begin mismatched++; $display("FAIL en_drop_no_grant: got %b want 0", any_rdy); end
        compared++; if (any_low !== 1'b0) begin mismatched++; $display("FAIL en_drop_tx_idle: got %b want 0", any_low); end
        step();
        req_valid = '0;
        en = 1'b1;
    endtask

    task automatic test_loopback();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] w;
        logic [N-1:0] rdy;
        logic [N-1:0] want;
        int r;
        int n;
        bit ok;
        do_reset();
        en = 1'b1;
        rx_on = 1'b1;
        for (int k = 0; k < 100; k++) begin
            r = $urandom_range(0, N - 1);
            w = W'($urandom);
            set_word(r, w);
            want = 4'(1 << r);
            req_valid = want;
            wait_grant(60, rdy, ok);
            compared++; if (!ok || rdy !== want) begin mismatched++; $display("FAIL loop_grant%0d: got %b want %b", k, rdy, want); end
            exp_q.push_back(w);
            step();
            req_valid = '0;
        end
        for (int i = 0; i < 40; i++) @(negedge clk);
        compared++; if (rx_q.size() != 100) begin mismatched++; $display("FAIL loop_word_count: got %0d want 100", rx_q.size()); end
        compared++; if (rx_pulses != 100) begin mismatched++; $display("FAIL loop_rx_ena_count: got %0d want 100", rx_pulses); end
        compared++; if (rx_errs != 0) begin mismatched++; $display("FAIL loop_stop_errors: got %0d want 0", rx_errs); end
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            compared++; if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL loop_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_on = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        req_valid = '0;
        req_data = '0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_ptr_wrap();
        test_reset_mid_frame();
        test_enable();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
